ac_motor_pwm: RTL and testbench



---
 rtl/ac_motor_pwm.sv | 88 ++++++++
 tb/tb_ac_motor_pwm.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ac_motor_pwm.sv
// ac_motor_pwm: two-phase sine-PWM generator with direction control and overcurrent shutdown.
// Duty values refresh only at the counter wrap so every PWM period is glitch-free.
module ac_motor_pwm #(
    parameter int PWM_W = 12,
    parameter int ACC_W = 16,
    parameter int LUT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cw,
    input  logic             ccw,
    input  logic [PWM_W-1:0] amplitude,
    input  logic [PWM_W-1:0] frequency,
    input  logic [PWM_W-1:0] adc_cmp,
    input  logic [PWM_W-1:0] adc,
    output logic             out_1,
    output logic             out_2,
    output logic             en_1,
    output logic             en_2,
    output logic             adc_latch
);
    localparam int N = 1 << LUT_W;
    localparam logic [LUT_W-1:0] QTR = LUT_W'(N / 4);
    localparam logic signed [2*PWM_W-1:0] MID = (2*PWM_W)'(1 << (PWM_W - 1));
    localparam logic [PWM_W-1:0] PRE_MID = PWM_W'((1 << (PWM_W - 1)) - 2);

    function automatic logic [N*PWM_W-1:0] sine_rom();
        logic [N*PWM_W-1:0] t;
        real s;
        t = '0;
        for (int i = 0; i < N; i++) begin
            s = real'((1 << (PWM_W - 1)) - 1) * $sin(6.283185307179586 * real'(i) / real'(N));
            t[i*PWM_W +: PWM_W] = PWM_W'(s >= 0.0 ? $rtoi(s + 0.5) : -$rtoi(0.5 - s));
        end
        return t;
    endfunction

    localparam logic [N*PWM_W-1:0] SIN = sine_rom();

    logic [PWM_W-1:0] cnt, d_a, d_b, n_a, n_b;
    logic [ACC_W-1:0] acc;
    logic [LUT_W-1:0] i_a, i_b;
    logic signed [PWM_W-1:0] s_a, s_b;
    logic signed [2*PWM_W-1:0] amp, p_a, p_b;
    logic trip, run, wrap, trip_n, en_n;

    assign run    = enable & (cw ^ ccw);
    assign wrap   = &cnt;
    // a trip is only released at a wrap that sees the current back in range
    assign trip_n = (adc > adc_cmp) | (trip & ~wrap);
    assign en_n   = run & ~trip_n;
    assign i_a    = acc[ACC_W-1 -: LUT_W];
    assign i_b    = cw ? i_a + QTR : i_a - QTR;
    assign s_a    = SIN[i_a*PWM_W +: PWM_W];
    assign s_b    = SIN[i_b*PWM_W +: PWM_W];
    assign amp    = $signed({{PWM_W{1'b0}}, amplitude});
    assign p_a    = (2*PWM_W)'(s_a) * amp;
    assign p_b    = (2*PWM_W)'(s_b) * amp;
    assign n_a    = PWM_W'(MID + (p_a >>> PWM_W));
    assign n_b    = PWM_W'(MID + (p_b >>> PWM_W));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            acc       <= '0;
            d_a       <= '0;
            d_b       <= '0;
            trip      <= 1'b0;
            en_1      <= 1'b0;
            en_2      <= 1'b0;
            out_1     <= 1'b0;
            out_2     <= 1'b0;
            adc_latch <= 1'b0;
        end else begin
            cnt       <= cnt + PWM_W'(1);
            acc       <= !run ? '0 : wrap ? acc + ACC_W'(frequency) : acc;
            d_a       <= wrap ? n_a : d_a;
            d_b       <= wrap ? n_b : d_b;
            trip      <= trip_n;
            en_1      <= en_n;
            en_2      <= en_n;
            out_1     <= (cnt < d_a) & en_n;
            out_2     <= (cnt < d_b) & en_n;
            adc_latch <= cnt == PRE_MID;
        end
    end
endmodule

// File: tb/tb_ac_motor_pwm.sv
// tb_ac_motor_pwm: directed checks of duty, direction, trip, run gating and reset.
// Expected values are queued as stimulus is applied and compared when the DUT responds.
module tb_ac_motor_pwm;
    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, cw = 1'b0, ccw = 1'b0;
    logic [11:0] amplitude = '0, frequency = '0, adc_cmp = 12'd3000, adc = 12'd0;
    logic out_1, out_2, en_1, en_2, adc_latch;
    int mc;
    int errors = 0, checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    ac_motor_pwm dut (
        .clk(clk), .reset(reset), .enable(enable), .cw(cw), .ccw(ccw),
        .amplitude(amplitude), .frequency(frequency), .adc_cmp(adc_cmp), .adc(adc),
        .out_1(out_1), .out_2(out_2), .en_1(en_1), .en_2(en_2), .adc_latch(adc_latch)
    );

    always #5 clk = ~clk;

    // reference copy of the PWM counter
    always @(posedge clk or posedge reset)
        if (reset) mc <= 0;
        else mc <= (mc + 1) % 4096;

    task automatic push(string t, logic [31:0] v);
        sb.push_back('{t, v});
    endtask

    task automatic pop(logic [31:0] obs);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: got %0d", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", e.tag, obs, e.val);
        end
    endtask

    task automatic pt(string t, logic [31:0] expv, logic [31:0] obs);
        push(t, expv);
        pop(obs);
    endtask

    task automatic wait_mc(int v);
        for (int i = 0; i < 4096 && mc != v; i++) @(negedge clk);
    endtask

    // one full period sampled from cnt=1 to cnt=0: out high count equals the duty value
    task automatic window(string t, int a, int b, int e);
        int ha = 0, hb = 0, he = 0, hl = 0, lp = -1;
        push({t, ".out_1"}, a);
        push({t, ".out_2"}, b);
        push({t, ".en_1"}, e);
        push({t, ".latch_n"}, 1);
        push({t, ".latch_pos"}, 2047);
        wait_mc(1);
        for (int i = 0; i < 4096; i++) begin
            if (i > 0) @(negedge clk);
            ha += int'(out_1);
            hb += int'(out_2);
            he += int'(en_1);
            if (adc_latch) begin
                hl++;
                lp = mc;
            end
        end
        pop(ha);
        pop(hb);
        pop(he);
        pop(hl);
        pop(lp);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        pt("reset_outs", 0, {out_1, out_2, en_1, en_2, adc_latch});
        reset = 1'b0;
        enable = 1'b1;
        ccw = 1'b1;
        frequency = 12'd2;
        @(negedge clk);
        pt("run_en", 2'b11, {en_1, en_2});
        window("first_period", 0, 0, 4096);
        window("amp0", 2048, 2048, 4096);
        // clockwise full scale from a cleared accumulator
        enable = 1'b0;
        @(negedge clk);
        pt("enable_drop", 0, {en_1, en_2});
        enable = 1'b1;
        cw = 1'b1;
        ccw = 1'b0;
        amplitude = 12'd4095;
        frequency = 12'd64;
        @(negedge clk);
        pt("enable_rise", 2'b11, {en_1, en_2});
        window("cw_idx0", 2048, 4094, 4096);
        window("cw_idx1", 2060, 4094, 4096);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        cw = 1'b0;
        ccw = 1'b1;
        @(negedge clk);
        window("ccw_idx0", 2048, 1, 4096);
        amplitude = 12'd0;
        adc = 12'd2500;
        window("amp_delayed", 2060, 1, 4096);
        window("amp_applied", 2048, 2048, 4096);
        // overcurrent burst
        wait_mc(100);
        pt("pre_trip", 2'b11, {en_1, out_1});
        adc = 12'd4000;
        @(negedge clk);
        pt("trip_1clk", 0, {en_1, en_2, out_1, out_2});
        repeat (4) @(negedge clk);
        adc = 12'd1000;
        @(negedge clk);
        pt("trip_hold", 0, {en_1, en_2});
        wait_mc(4095);
        pt("trip_until_wrap", 0, {en_1, en_2});
        @(negedge clk);
        pt("trip_clear_wrap", 2'b11, {en_1, en_2});
        @(negedge clk);
        pt("out_restored", 2'b11, {out_1, out_2});
        wait_mc(10);
        adc = 12'd3000;
        @(negedge clk);
        pt("equal_no_trip", 2'b11, {en_1, en_2});
        wait_mc(4000);
        adc = 12'd3001;
        @(negedge clk);
        pt("over_by_one", 0, {en_1, en_2});
        wait_mc(0);
        pt("held_across_wrap", 0, {en_1, en_2});
        adc = 12'd0;
        wait_mc(4095);
        pt("clear_only_at_wrap", 0, {en_1, en_2});
        @(negedge clk);
        pt("clear_next_wrap", 2'b11, {en_1, en_2});
        // both directions requested, then enable low
        cw = 1'b1;
        @(negedge clk);
        pt("both_dirs", 0, {en_1, en_2, out_1, out_2});
        window("both_dirs", 0, 0, 0);
        cw = 1'b0;
        enable = 1'b0;
        amplitude = 12'd4095;
        @(negedge clk);
        pt("disabled", 0, {en_1, en_2, out_1, out_2});
        enable = 1'b1;
        @(negedge clk);
        window("acc_cleared", 2048, 1, 4096);
        // asynchronous reset mid-period
        wait_mc(500);
        pt("pre_reset", 3'b111, {out_1, en_1, en_2});
        reset = 1'b1;
        #1;
        pt("reset_async", 0, {out_1, out_2, en_1, en_2, adc_latch});
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        window("after_reset", 0, 0, 4096);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
